display_scan: RTL and testbench

Time-multiplexed controller for a multi-digit 7-segment display. Holds a hex value, scans one digit per refresh slot, decodes each digit's nibble to segments and drives a one-hot digit select. A guard interval between slots suppresses ghosting. A valid/ready handshake loads new values, and they take effect only at frame boundaries so the display never shows a torn value. Sits between the application logic and the display PMOD pins.

---
 rtl/display_scan.sv | 150 +++++++++++++++
 tb/tb_display_scan.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/display_scan.sv
// display_scan: time-multiplexed 7-segment scanner with guarded slots,
// frame-aligned value updates and optional leading-zero blanking.
module display_scan #(
    parameter int DIGITS       = 2,
    parameter int REFRESH_DIV  = 12000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [4*DIGITS-1:0]   i_value,
    input  logic [DIGITS-1:0]     i_dp,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic                  i_blank_lz,
    output logic [6:0]            o_segments,
    output logic                  o_dp,
    output logic [DIGITS-1:0]     o_digit_sel,
    output logic                  o_frame
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [PW-1:0] P_LAST  = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0] P_BLANK = PW'(BLANK_CYCLES);
    localparam logic [DW-1:0] D_LAST  = DW'(DIGITS - 1);

    logic [PW-1:0]         p_q, p_d;
    logic [DW-1:0]         d_q, d_d;
    logic [4*DIGITS-1:0]   act_val_q, act_val_d;
    logic [DIGITS-1:0]     act_dp_q, act_dp_d;
    logic [4*DIGITS-1:0]   pend_val_q, pend_val_d;
    logic [DIGITS-1:0]     pend_dp_q, pend_dp_d;
    logic                  pend_q, pend_d;
    logic                  frame_q, frame_d;
    logic                  blank_lz_q;

    logic                  slot_end;
    logic                  frame_edge;
    logic                  accept;
    logic                  in_blank;
    logic                  lz_hit;
    logic [3:0]            nib;
    logic                  nib_dp;

    // Segment pattern {g,f,e,d,c,b,a} for one hex nibble.
    function automatic logic [6:0] decode(input logic [3:0] v);
        case (v)
            4'h0: decode = 7'h3F;
            4'h1: decode = 7'h06;
            4'h2: decode = 7'h5B;
            4'h3: decode = 7'h4F;
            4'h4: decode = 7'h66;
            4'h5: decode = 7'h6D;
            4'h6: decode = 7'h7D;
            4'h7: decode = 7'h07;
            4'h8: decode = 7'h7F;
            4'h9: decode = 7'h67;
            4'hA: decode = 7'h77;
            4'hB: decode = 7'h7C;
            4'hC: decode = 7'h39;
            4'hD: decode = 7'h5E;
            4'hE: decode = 7'h79;
            default: decode = 7'h71;
        endcase
    endfunction

    assign slot_end   = (p_q == P_LAST);
    assign frame_edge = slot_end && (d_q == D_LAST);
    assign accept     = i_valid && !pend_q;

    // Next state: scan counters, handshake capture and frame-edge commit.
    always_comb begin
        p_d        = p_q + 1'b1;
        d_d        = d_q;
        act_val_d  = act_val_q;
        act_dp_d   = act_dp_q;
        pend_val_d = pend_val_q;
        pend_dp_d  = pend_dp_q;
        pend_d     = pend_q;
        frame_d    = frame_edge;
        if (slot_end) begin
            p_d = '0;
            d_d = frame_edge ? '0 : d_q + 1'b1;
        end
        // accept implies nothing pending, so it never collides with a commit
        if (accept) begin
            pend_val_d = i_value;
            pend_dp_d  = i_dp;
            pend_d     = 1'b1;
        end else if (frame_edge && pend_q) begin
            act_val_d = pend_val_q;
            act_dp_d  = pend_dp_q;
            pend_d    = 1'b0;
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            p_q        <= '0;
            d_q        <= '0;
            act_val_q  <= '0;
            act_dp_q   <= '0;
            pend_val_q <= '0;
            pend_dp_q  <= '0;
            pend_q     <= 1'b0;
            frame_q    <= 1'b0;
            blank_lz_q <= 1'b0;
        end else begin
            p_q        <= p_d;
            d_q        <= d_d;
            act_val_q  <= act_val_d;
            act_dp_q   <= act_dp_d;
            pend_val_q <= pend_val_d;
            pend_dp_q  <= pend_dp_d;
            pend_q     <= pend_d;
            frame_q    <= frame_d;
            blank_lz_q <= i_blank_lz;
        end
    end

    // Display outputs from registered state only; the blanking enable is
    // registered so no input reaches an output combinationally.
    always_comb begin
        nib         = 4'h0;
        nib_dp      = 1'b0;
        lz_hit      = blank_lz_q && (d_q != '0);
        in_blank    = (BLANK_CYCLES > 0) && (p_q < P_BLANK);
        o_segments  = '0;
        o_dp        = 1'b0;
        o_digit_sel = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (d_q == DW'(i)) begin
                nib    = act_val_q[4*i +: 4];
                nib_dp = act_dp_q[i];
            end
            if ((DW'(i) >= d_q) && (act_val_q[4*i +: 4] != 4'h0))
                lz_hit = 1'b0;
        end
        if (!in_blank) begin
            o_digit_sel = DIGITS'(1) << d_q;
            o_dp        = nib_dp;
            o_segments  = lz_hit ? 7'h00 : decode(nib);
        end
    end

    assign o_ready = !pend_q;
    assign o_frame = frame_q;

endmodule

// File: tb/tb_display_scan.sv
// Directed bench for display_scan with DIGITS=2, REFRESH_DIV=8, BLANK_CYCLES=2.
module tb_display_scan;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] value = 8'h00;
    logic [1:0] dp = 2'b00;
    logic       valid = 1'b0;
    logic       blank_lz = 1'b0;
    logic       ready;
    logic [6:0] seg;
    logic       odp;
    logic [1:0] sel;
    logic       frame;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc;

    display_scan #(.DIGITS(2), .REFRESH_DIV(8), .BLANK_CYCLES(2)) dut (
        .i_clk       (clk),
        .i_reset     (rst),
        .i_value     (value),
        .i_dp        (dp),
        .i_valid     (valid),
        .o_ready     (ready),
        .i_blank_lz  (blank_lz),
        .o_segments  (seg),
        .o_dp        (odp),
        .o_digit_sel (sel),
        .o_frame     (frame)
    );

    always #5 clk = ~clk;

    // cycle n = number of rising edges since reset release
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic goto(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic show(input string tag, input int n, input logic [1:0] e_sel,
                        input logic [6:0] e_seg, input logic e_dp);
        goto(n);
        check({tag, ".sel"}, sel, e_sel);
        check({tag, ".seg"}, seg, e_seg);
        check({tag, ".dp"},  odp, e_dp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        // idle after reset
        repeat (2) @(negedge clk);
        check("rst.seg",   seg, 7'h00);
        check("rst.sel",   sel, 2'b00);
        check("rst.dp",    odp, 1'b0);
        check("rst.frame", frame, 1'b0);
        check("rst.ready", ready, 1'b1);
        rst = 1'b0;
        show("idle1",  1, 2'b00, 7'h00, 1'b0);
        show("idle2",  2, 2'b01, 7'h3F, 1'b0);
        show("idle7",  7, 2'b01, 7'h3F, 1'b0);
        show("idle10", 10, 2'b10, 7'h3F, 1'b0);
        show("idle15", 15, 2'b10, 7'h3F, 1'b0);
        check("idle.frame15", frame, 1'b0);
        goto(16); check("idle.frame16", frame, 1'b1);
        goto(17); check("idle.frame17", frame, 1'b0);
        goto(32); check("idle.frame32", frame, 1'b1);

        // load 0x12 at edge 3, busy 0x34 ignored, accept on frame edge 32
        do_reset();
        goto(2); value = 8'h12; dp = 2'b01; valid = 1'b1;
        goto(3); check("ld.ready3", ready, 1'b0);
        value = 8'h34; dp = 2'b10;
        goto(15); check("ld.ready15", ready, 1'b0);
        valid = 1'b0;
        goto(16); check("ld.ready16", ready, 1'b1);
        show("ld17", 17, 2'b00, 7'h00, 1'b0);
        show("ld18", 18, 2'b01, 7'h5B, 1'b1);
        show("ld23", 23, 2'b01, 7'h5B, 1'b1);
        show("ld26", 26, 2'b10, 7'h06, 1'b0);
        goto(31); value = 8'hAF; dp = 2'b10; valid = 1'b1;
        goto(32); check("fe.ready32", ready, 1'b0);
        valid = 1'b0;
        show("fe34", 34, 2'b01, 7'h5B, 1'b1);
        goto(48); check("fe.ready48", ready, 1'b1);
        show("hex50", 50, 2'b01, 7'h71, 1'b0);
        show("hex58", 58, 2'b10, 7'h77, 1'b1);

        // leading-zero blanking; accept exactly at edge 16
        blank_lz = 1'b1;
        do_reset();
        show("lz0.d0", 2, 2'b01, 7'h3F, 1'b0);
        show("lz0.d1", 10, 2'b10, 7'h00, 1'b0);
        goto(15); value = 8'h05; dp = 2'b00; valid = 1'b1;
        goto(16); check("e16.ready16", ready, 1'b0);
        valid = 1'b0;
        show("e16.18", 18, 2'b01, 7'h3F, 1'b0);
        goto(32); check("e16.ready32", ready, 1'b1);
        show("e16.34", 34, 2'b01, 7'h6D, 1'b0);
        show("lz5.d1", 42, 2'b10, 7'h00, 1'b0);
        blank_lz = 1'b0;

        // reset while a load is pending
        do_reset();
        goto(16); value = 8'h88; dp = 2'b11; valid = 1'b1;
        goto(17); valid = 1'b0;
        check("mr.ready17", ready, 1'b0);
        show("mr20", 20, 2'b01, 7'h3F, 1'b0);
        #1 rst = 1'b1;
        #1;
        check("mr.seg",   seg, 7'h00);
        check("mr.sel",   sel, 2'b00);
        check("mr.dp",    odp, 1'b0);
        check("mr.frame", frame, 1'b0);
        check("mr.ready", ready, 1'b1);
        @(negedge clk); rst = 1'b0;
        goto(16); check("mr.ready16", ready, 1'b1);
        show("mr18", 18, 2'b01, 7'h3F, 1'b0);
        show("mr26", 26, 2'b10, 7'h3F, 1'b0);
        show("mr34", 34, 2'b01, 7'h3F, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
